ps2_dev_tx: RTL and testbench

- PS/2 device-side transmitter; the opposite end of the keyboard receive path on top's ps2_clk/ps2_data.
- Accepts scan-code bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte as an 11-bit PS/2 frame, driving ps2_clk and ps2_data as a keyboard would.
- Used as an on-chip keyboard emulator to exercise the receiver path in simulation and on the board.

---
 rtl/ps2_dev_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_dev_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dev_tx.sv
// PS/2 device-side transmitter: buffers scan-code bytes in a small FIFO and
// serialises each as an 11-bit keyboard frame on ps2_clk/ps2_data.
module ps2_dev_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_HP     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned GW = (GAP_HP > 1) ? $clog2(GAP_HP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HP - 1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP,
    S_RETRY
  } state_t;

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          push, pop;

  assign in_ready   = (level != LVL_FULL);
  assign push       = in_valid && in_ready;
  assign fifo_level = level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Frame sequencer
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [3:0]    bit_idx, bit_n;
  logic [10:0]   shreg, shreg_n;
  logic [7:0]    cur_byte, byte_n;
  logic          data_q, data_n;
  logic          clk_q, clk_n;
  logic          hp_end, launch;
  logic [7:0]    launch_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gap_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      cur_byte <= '0;
      data_q   <= 1'b1;
      clk_q    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      gap_cnt  <= gap_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      cur_byte <= byte_n;
      data_q   <= data_n;
      clk_q    <= clk_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    gap_n       = gap_cnt;
    bit_n       = bit_idx;
    shreg_n     = shreg;
    byte_n      = cur_byte;
    data_n      = data_q;
    pop         = 1'b0;
    launch      = 1'b0;
    launch_byte = cur_byte;
    hp_end      = (cnt == CNT_LAST);

    case (state)
      S_IDLE: begin
        data_n = 1'b1;
        if ((level != '0) && !inhibit) begin
          launch      = 1'b1;
          pop         = 1'b1;
          launch_byte = mem[rd_ptr];
        end
      end
      S_RETRY: begin
        data_n = 1'b1;
        if (!inhibit) launch = 1'b1;
      end
      S_HIGH: begin
        if (inhibit && (bit_idx <= 4'd9)) begin
          state_n = S_RETRY;
          cnt_n   = '0;
          data_n  = 1'b1;
        end else if (hp_end) begin
          state_n = S_LOW;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LOW: begin
        if (inhibit && (bit_idx <= 4'd9)) begin
          state_n = S_RETRY;
          cnt_n   = '0;
          data_n  = 1'b1;
        end else if (hp_end) begin
          cnt_n = '0;
          if (bit_idx < 4'd10) begin
            bit_n   = bit_idx + 4'd1;
            shreg_n = {1'b1, shreg[10:1]};
            data_n  = shreg[1];
            state_n = S_HIGH;
          end else begin
            state_n = S_GAP;
            data_n  = 1'b1;
            gap_n   = '0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        data_n = 1'b1;
        if (hp_end) begin
          cnt_n = '0;
          if (gap_cnt == GAP_LAST) begin
            state_n = S_IDLE;
            gap_n   = '0;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // IDLE pop and RETRY relaunch share one launch path; the retained byte
    // is reloaded so an aborted frame restarts from its start bit.
    if (launch) begin
      byte_n  = launch_byte;
      shreg_n = make_frame(launch_byte);
      bit_n   = '0;
      data_n  = 1'b0;
      cnt_n   = '0;
      state_n = S_HIGH;
    end

    clk_n = (state_n != S_LOW);
  end

  assign ps2_clk  = clk_q;
  assign ps2_data = data_q;
  assign busy     = (level != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_ps2_dev_tx.sv
// Bench for ps2_dev_tx: a line monitor decodes completed frames and a byte
// scoreboard queue holds what each frame should carry.
module tb_ps2_dev_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned GAP_HP     = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = '0;
  logic       inhibit  = 1'b0;
  logic       in_ready, ps2_clk, ps2_data, busy;
  logic [2:0] fifo_level;

  ps2_dev_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_HP    (GAP_HP),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .inhibit   (inhibit),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [10:0] rx_bits [64];
  int          rx_start [64];
  int          rx_end [64];
  int          rx_cnt = 0;
  int          fall_total = 0;
  int          rd_idx = 0;

  // Line monitor: collects bits on ps2_clk falling edges; a long high run
  // with a partial frame means the frame was aborted.
  initial begin
    logic        pc, pd;
    logic [10:0] bits;
    int          nb, hi_run, st;
    pc = 1'b1; pd = 1'b1; bits = '0; nb = 0; hi_run = 0; st = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nb = 0; hi_run = 0; pc = 1'b1; pd = 1'b1;
      end else begin
        if (nb == 0 && pd && !ps2_data && ps2_clk) st = cyc;
        if (pc && !ps2_clk) begin
          if (nb < 11) bits[nb] = ps2_data;
          nb++;
          fall_total++;
        end
        if (!pc && ps2_clk && nb == 11) begin
          if (rx_cnt < 64) begin
            rx_bits[rx_cnt]  = bits;
            rx_start[rx_cnt] = st;
            rx_end[rx_cnt]   = cyc;
          end
          rx_cnt++;
          nb = 0;
        end
        hi_run = ps2_clk ? hi_run + 1 : 0;
        if (hi_run > int'(3 * CLK_DIV)) nb = 0;
        pc = ps2_clk;
        pd = ps2_data;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic expect_ok);
    checks++;
    if (in_ready !== expect_ok) begin
      errors++;
      $display("FAIL push_ready: in_ready=%b expected %b (byte %02h)", in_ready, expect_ok, b);
    end
    in_valid = 1'b1;
    in_data  = b;
    step();
    in_valid = 1'b0;
    if (expect_ok) exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input string name);
    int budget;
    budget = 600 * n;
    while (rx_cnt < rd_idx + n && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (rx_cnt < rd_idx + n) begin
      errors++;
      $display("FAIL %s_timeout: frames=%0d expected %0d", name, rx_cnt - rd_idx, n);
    end
  endtask

  task automatic wait_falls(input int target, input string name);
    int budget;
    budget = 400;
    while (fall_total < target && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (fall_total < target) begin
      errors++;
      $display("FAIL %s_falls_timeout: falls=%0d expected %0d", name, fall_total, target);
    end
  endtask

  task automatic check_frame(input string name);
    logic [7:0]  e;
    logic [10:0] want;
    checks++;
    if (exp_q.size() == 0 || rd_idx >= rx_cnt) begin
      errors++;
      $display("FAIL %s_frame: frames=%0d consumed=%0d expected_left=%0d", name, rx_cnt, rd_idx, exp_q.size());
      return;
    end
    e    = exp_q.pop_front();
    want = {1'b1, ~^e, e, 1'b0};
    if (rx_bits[rd_idx] !== want) begin
      errors++;
      $display("FAIL %s_frame: bits=%03h expected %03h (byte %02h)", name, rx_bits[rd_idx], want, e);
    end
    rd_idx++;
  endtask

  task automatic wait_idle(input string name);
    int budget;
    budget = 400;
    while (busy !== 1'b0 && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({ps2_clk, ps2_data} !== 2'b11) begin
      errors++;
      $display("FAIL reset_lines: clk/data=%b expected 11", {ps2_clk, ps2_data});
    end
    checks++;
    if ({in_ready, busy, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/level=%b expected 10000", {in_ready, busy, fifo_level});
    end
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    int f0;
    f0 = fall_total;
    push(8'h1C, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b expected 1", busy);
    end
    wait_frames(1, "single");
    if (rd_idx < rx_cnt) begin
      checks++;
      if (rx_bits[rd_idx] !== 11'b100_0011_1000) begin
        errors++;
        $display("FAIL single_bits: bits=%b expected 10000111000", rx_bits[rd_idx]);
      end
      checks++;
      if (rx_end[rd_idx] - rx_start[rd_idx] !== 88) begin
        errors++;
        $display("FAIL single_length: cycles=%0d expected 88", rx_end[rd_idx] - rx_start[rd_idx]);
      end
    end
    check_frame("single");
    wait_idle("single");
    checks++;
    if (fall_total - f0 !== 11) begin
      errors++;
      $display("FAIL single_falls: falls=%0d expected 11", fall_total - f0);
    end
  endtask

  task automatic test_parity();
    push(8'h00, 1'b1);
    push(8'hF0, 1'b1);
    wait_frames(2, "parity");
    if (rd_idx + 1 < rx_cnt) begin
      checks++;
      if ({rx_bits[rd_idx][9], rx_bits[rd_idx+1][9]} !== 2'b11) begin
        errors++;
        $display("FAIL parity_bits: got %b expected 11", {rx_bits[rd_idx][9], rx_bits[rd_idx+1][9]});
      end
      checks++;
      if (rx_start[rd_idx+1] - rx_start[rd_idx] !== 105) begin
        errors++;
        $display("FAIL parity_spacing: cycles=%0d expected 105", rx_start[rd_idx+1] - rx_start[rd_idx]);
      end
    end
    check_frame("parity0");
    check_frame("parity1");
    wait_idle("parity");
  endtask

  task automatic test_backpressure();
    inhibit = 1'b1;
    step();
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    push(8'h55, 1'b0);
    repeat (3) step();
    checks++;
    if ({in_ready, fifo_level, busy} !== {1'b0, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL bp_full: ready/level/busy=%b expected 01001", {in_ready, fifo_level, busy});
    end
    inhibit = 1'b0;
    step();
    checks++;
    if ({in_ready, fifo_level} !== {1'b1, 3'd3}) begin
      errors++;
      $display("FAIL bp_first_pop: ready/level=%b expected 1011", {in_ready, fifo_level});
    end
    wait_frames(4, "bp");
    for (int i = 0; i < 4; i++) check_frame("bp");
    wait_idle("bp");
  endtask

  task automatic test_abort();
    int f0, n0;
    logic [2:0] lvl;
    f0 = fall_total;
    push(8'hAA, 1'b1);
    wait_falls(f0 + 4, "abort");
    inhibit = 1'b1;
    lvl = fifo_level;
    n0  = rx_cnt;
    step();
    checks++;
    if ({ps2_clk, ps2_data, busy} !== 3'b111) begin
      errors++;
      $display("FAIL abort_release: clk/data/busy=%b expected 111", {ps2_clk, ps2_data, busy});
    end
    repeat (20) step();
    checks++;
    if (fifo_level !== lvl) begin
      errors++;
      $display("FAIL abort_level: level=%0d expected %0d", fifo_level, lvl);
    end
    inhibit = 1'b0;
    wait_frames(1, "abort");
    if (rd_idx < rx_cnt) begin
      checks++;
      if (rx_bits[rd_idx][9] !== 1'b1) begin
        errors++;
        $display("FAIL abort_parity: parity=%b expected 1", rx_bits[rd_idx][9]);
      end
    end
    check_frame("abort");
    wait_idle("abort");
    checks++;
    if ({rx_cnt - n0, 32'(fifo_level)} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL abort_once: frames=%0d level=%0d expected 1 frame, level 0", rx_cnt - n0, fifo_level);
    end
  endtask

  task automatic test_stop_inhibit();
    int f0, n0;
    f0 = fall_total;
    n0 = rx_cnt;
    push(8'h5A, 1'b1);
    wait_falls(f0 + 11, "stop");
    inhibit = 1'b1;
    wait_frames(1, "stop");
    check_frame("stop");
    wait_idle("stop");
    repeat (50) step();
    checks++;
    if ({fall_total - f0, rx_cnt - n0} !== {32'd11, 32'd1}) begin
      errors++;
      $display("FAIL stop_no_retx: falls=%0d frames=%0d expected 11 falls, 1 frame", fall_total - f0, rx_cnt - n0);
    end
    inhibit = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int f0, fr, n0;
    f0 = fall_total;
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    exp_q.delete();
    wait_falls(f0 + 6, "rstmid");
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ps2_clk, ps2_data, busy, fifo_level} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL rstmid_async: clk/data/busy/level=%b expected 110000", {ps2_clk, ps2_data, busy, fifo_level});
    end
    repeat (3) step();
    rst = 1'b1;
    fr = fall_total;
    n0 = rx_cnt;
    repeat (200) step();
    checks++;
    if ({fall_total, rx_cnt, 31'd0, busy} !== {fr, n0, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_quiet: falls=%0d frames=%0d busy=%b expected %0d, %0d, 0", fall_total, rx_cnt, busy, fr, n0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_backpressure();
    test_abort();
    test_stop_inhibit();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
